controle_linha_envase: RTL and testbench
========================================

Name: controle_linha_envase

Overview:
Top-level sequencer for one bottling lane: conveyor motor, filling valve and the sealing station.
- Moves each bottle to the fill point, fills to level with a timeout, moves it to the sealing point, then requests a seal and waits for completion.
- Tracks cork stock, units per case (12) and completed cases.
- Raises a latched, coded alarm that persists until operator acknowledge.

Parameters:
ROLHA_MAX, 20, cork reservoir capacity; stock value loaded on reset and on refill (1..255)
ROLHA_MIN, 3, low-stock threshold; rolha_baixa=1 when stock <= ROLHA_MIN
FILL_TIMEOUT, 50, max cycles in FILL without nivel before fill-fault alarm (2..255)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  level; run request
stop  in  1  pulse; stop request, latched internally
ack  in  1  operator alarm acknowledge
garrafa_in  in  1  bottle present at fill position
nivel  in  1  fill level reached
garrafa_ved  in  1  bottle present at sealing position
ved_done  in  1  sealing station completion pulse
ved_alarme  in  1  sealing station fault
recarga  in  1  pulse; cork reservoir refilled
motor  out  1  conveyor run
valvula  out  1  fill valve open
ved_req  out  1  seal request to sealing station
alarme  out  1  alarm lamp
alarme_cod  out  2  00 none, 01 fill timeout, 10 seal fault, 11 reserved
rolha_stock  out  8  corks remaining
rolha_baixa  out  1  low cork stock
unidades  out  4  bottles in current case, 0..11
caixas  out  8  completed cases, saturating at 255
caixa_pronta  out  1  one-cycle pulse when a case completes

Behaviour:
- Reset values:
  - state IDLE; motor, valvula, ved_req, alarme, caixa_pronta = 0; alarme_cod = 00.
  - rolha_stock = ROLHA_MAX; unidades = 0; caixas = 0; stop latch = 0; fill timer = 0.
  - Reset mid-operation aborts immediately to these values.
- Outputs are Moore, decoded from registered state:
  - motor = 1 in MOVE_FILL and MOVE_SEAL.
  - valvula = 1 in FILL.
  - ved_req = 1 in SEAL.
  - alarme = 1 in ALARM.
- Stop latch:
  - Set by stop in any state except IDLE.
  - Cleared on entry to IDLE.
- IDLE: start=1 and rolha_stock>0 -> MOVE_FILL; otherwise stay.
- MOVE_FILL:
  - stop latched -> IDLE (no bottle in process).
  - Else garrafa_in=1 -> FILL; timer cleared.
- FILL:
  - Timer increments each cycle.
  - nivel=1 -> MOVE_SEAL (nivel has priority over timeout in the same cycle).
  - Else timer == FILL_TIMEOUT-1 -> ALARM with code 01. The valve is open for exactly FILL_TIMEOUT cycles.
- MOVE_SEAL: garrafa_ved=1 -> SEAL. A stop here is latched, not honoured yet.
- SEAL:
  - ved_alarme=1 -> ALARM with code 10. This has priority over a simultaneous ved_done, and nothing is counted.
  - Else ved_done=1:
    - rolha_stock decrements by 1.
    - unidades increments; 11 -> 0 wraps, and in that same cycle caixas increments (saturating at 255) and caixa_pronta pulses on the next cycle.
    - Next state is IDLE if the stop latch is set or the new stock is 0; otherwise MOVE_FILL.
- ALARM:
  - All actuators off; alarme_cod is held.
  - ack=1 and ved_alarme=0 -> IDLE, with alarme_cod cleared to 00.
  - ack while ved_alarme=1 is ignored.
- recarga:
  - Sets rolha_stock = ROLHA_MAX in any state.
  - recarga wins over a simultaneous decrement.
- Stock never underflows. A decrement at 0 is impossible by construction: IDLE does not start with stock 0, and SEAL exits on 0.
- rolha_baixa is combinational from rolha_stock.
- start is sampled only in IDLE; dropping start mid-cycle does not abort a bottle (use stop).

Test Plan:
- Nominal bottle: reset, start=1, garrafa_in at cycle 3, nivel after 5 cycles in FILL, garrafa_ved, ved_done -> motor/valvula/ved_req in sequence; rolha_stock 20->19, unidades 0->1, state back in MOVE_FILL.
- Case completion: run 12 bottles -> unidades wraps 11->0, caixas=1, caixa_pronta high exactly one cycle. Preload 255 cases via 3060 bottles (with recarga) -> caixas stays 255.
- Fill timeout: FILL entered, nivel held 0 -> valvula high exactly 50 cycles, then alarme=1, cod=01. ack -> IDLE, cod=00. nivel and timeout in the same cycle -> MOVE_SEAL, no alarm.
- Seal fault: in SEAL assert ved_alarme and ved_done together -> ALARM cod=10, stock and unidades unchanged. ack while ved_alarme=1 -> stays ALARM. Drop ved_alarme, then ack -> IDLE.
- Stop/stock: stop pulse during FILL -> bottle finishes sealing, then IDLE. With stock=1, ved_done -> stock 0, IDLE, rolha_baixa=1, start ignored. recarga -> stock 20 and start resumes. recarga coincident with ved_done -> stock 20.
- Async reset asserted in SEAL between clock edges -> all outputs are at reset values before the next edge.

Source files
------------

// File: rtl/controle_linha_envase.sv
// Bottling lane sequencer: conveyor, fill valve and sealing handshake, with
// cork stock tracking, case counting and a latched coded alarm.
module controle_linha_envase #(
    parameter int ROLHA_MAX    = 20,
    parameter int ROLHA_MIN    = 3,
    parameter int FILL_TIMEOUT = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       ack,
    input  logic       garrafa_in,
    input  logic       nivel,
    input  logic       garrafa_ved,
    input  logic       ved_done,
    input  logic       ved_alarme,
    input  logic       recarga,
    output logic       motor,
    output logic       valvula,
    output logic       ved_req,
    output logic       alarme,
    output logic [1:0] alarme_cod,
    output logic [7:0] rolha_stock,
    output logic       rolha_baixa,
    output logic [3:0] unidades,
    output logic [7:0] caixas,
    output logic       caixa_pronta
);

    localparam logic [7:0] STOCK_MAX = 8'(ROLHA_MAX);
    localparam logic [7:0] STOCK_MIN = 8'(ROLHA_MIN);
    localparam logic [7:0] TMO_LAST  = 8'(FILL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, MOVE_FILL, FILL, MOVE_SEAL, SEAL, ALARM
    } estado_t;

    estado_t    estado;
    logic       stop_lat;
    logic [7:0] timer;
    logic [7:0] stock_novo;

    // A refill in the same cycle as a seal wins over the decrement.
    assign stock_novo = recarga ? STOCK_MAX : rolha_stock - 8'd1;

    assign motor       = (estado == MOVE_FILL) || (estado == MOVE_SEAL);
    assign valvula     = (estado == FILL);
    assign ved_req     = (estado == SEAL);
    assign alarme      = (estado == ALARM);
    assign rolha_baixa = (rolha_stock <= STOCK_MIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado       <= IDLE;
            stop_lat     <= 1'b0;
            timer        <= 8'd0;
            alarme_cod   <= 2'b00;
            rolha_stock  <= STOCK_MAX;
            unidades     <= 4'd0;
            caixas       <= 8'd0;
            caixa_pronta <= 1'b0;
        end else begin
            caixa_pronta <= 1'b0;
            if (stop && estado != IDLE) stop_lat <= 1'b1;
            if (recarga) rolha_stock <= STOCK_MAX;

            // Every transition into IDLE also clears the stop latch; these
            // later assignments override the set above.
            case (estado)
                IDLE: begin
                    if (start && rolha_stock != 8'd0) estado <= MOVE_FILL;
                end
                MOVE_FILL: begin
                    if (stop_lat) begin
                        estado   <= IDLE;
                        stop_lat <= 1'b0;
                    end else if (garrafa_in) begin
                        estado <= FILL;
                        timer  <= 8'd0;
                    end
                end
                FILL: begin
                    timer <= timer + 8'd1;
                    if (nivel) begin
                        estado <= MOVE_SEAL;
                    end else if (timer == TMO_LAST) begin
                        estado     <= ALARM;
                        alarme_cod <= 2'b01;
                    end
                end
                MOVE_SEAL: begin
                    if (garrafa_ved) estado <= SEAL;
                end
                SEAL: begin
                    if (ved_alarme) begin
                        estado     <= ALARM;
                        alarme_cod <= 2'b10;
                    end else if (ved_done) begin
                        rolha_stock <= stock_novo;
                        if (unidades == 4'd11) begin
                            unidades     <= 4'd0;
                            caixa_pronta <= 1'b1;
                            if (caixas != 8'hFF) caixas <= caixas + 8'd1;
                        end else begin
                            unidades <= unidades + 4'd1;
                        end
                        if (stop_lat || stock_novo == 8'd0) begin
                            estado   <= IDLE;
                            stop_lat <= 1'b0;
                        end else begin
                            estado <= MOVE_FILL;
                        end
                    end
                end
                ALARM: begin
                    if (ack && !ved_alarme) begin
                        estado     <= IDLE;
                        alarme_cod <= 2'b00;
                        stop_lat   <= 1'b0;
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_linha_envase.sv
// Directed bench for controle_linha_envase with hand-computed expectations.
module tb_controle_linha_envase;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, ack, garrafa_in, nivel, garrafa_ved;
    logic       ved_done, ved_alarme, recarga;
    logic       motor, valvula, ved_req, alarme, rolha_baixa, caixa_pronta;
    logic [1:0] alarme_cod;
    logic [7:0] rolha_stock, caixas;
    logic [3:0] unidades;

    int n_chk  = 0;
    int n_pass = 0;

    controle_linha_envase dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .ack(ack),
        .garrafa_in(garrafa_in), .nivel(nivel), .garrafa_ved(garrafa_ved),
        .ved_done(ved_done), .ved_alarme(ved_alarme), .recarga(recarga),
        .motor(motor), .valvula(valvula), .ved_req(ved_req), .alarme(alarme),
        .alarme_cod(alarme_cod), .rolha_stock(rolha_stock),
        .rolha_baixa(rolha_baixa), .unidades(unidades), .caixas(caixas),
        .caixa_pronta(caixa_pronta)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From MOVE_FILL, run one bottle through to the ved_done edge.
    task automatic garrafa();
        garrafa_in = 1'b1; tick();
        garrafa_in = 1'b0; nivel = 1'b1; tick();
        nivel = 1'b0; garrafa_ved = 1'b1; tick();
        garrafa_ved = 1'b0; ved_done = 1'b1; tick();
        ved_done = 1'b0;
    endtask

    initial begin
        int cnt;
        {start, stop, ack, garrafa_in, nivel, garrafa_ved, ved_done, ved_alarme, recarga} = '0;
        reset = 1'b1;
        #12;
        chk("rst_motor", motor, 0);
        chk("rst_valvula", valvula, 0);
        chk("rst_ved_req", ved_req, 0);
        chk("rst_alarme", alarme, 0);
        chk("rst_cod", alarme_cod, 0);
        chk("rst_stock", rolha_stock, 20);
        chk("rst_baixa", rolha_baixa, 0);
        chk("rst_unid", unidades, 0);
        chk("rst_caixas", caixas, 0);
        chk("rst_pronta", caixa_pronta, 0);
        reset = 1'b0;
        tick();

        // Nominal bottle
        start = 1'b1; tick();
        chk("nom_motor_mf", motor, 1);
        tick();
        garrafa_in = 1'b1; tick(); garrafa_in = 1'b0;
        chk("nom_valvula", valvula, 1);
        chk("nom_motor_fill", motor, 0);
        repeat (5) tick();
        chk("nom_valvula_5", valvula, 1);
        nivel = 1'b1; tick(); nivel = 1'b0;
        chk("nom_motor_ms", motor, 1);
        chk("nom_valv_off", valvula, 0);
        garrafa_ved = 1'b1; tick(); garrafa_ved = 1'b0;
        chk("nom_ved_req", ved_req, 1);
        ved_done = 1'b1; tick(); ved_done = 1'b0;
        chk("nom_ved_off", ved_req, 0);
        chk("nom_motor_back", motor, 1);
        chk("nom_stock", rolha_stock, 19);
        chk("nom_unid", unidades, 1);

        // Case completion
        repeat (10) garrafa();
        chk("case_unid11", unidades, 11);
        chk("case_caixas0", caixas, 0);
        garrafa();
        chk("case_wrap", unidades, 0);
        chk("case_caixas1", caixas, 1);
        chk("case_pronta", caixa_pronta, 1);
        chk("case_stock", rolha_stock, 8);
        tick();
        chk("case_pronta_off", caixa_pronta, 0);

        // Fill timeout: valve open exactly 50 cycles
        garrafa_in = 1'b1; tick(); garrafa_in = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (!valvula) break;
            cnt++;
            tick();
        end
        chk("tmo_cycles", cnt, 50);
        chk("tmo_alarme", alarme, 1);
        chk("tmo_cod", alarme_cod, 1);
        chk("tmo_motor", motor, 0);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("tmo_ack_alarme", alarme, 0);
        chk("tmo_ack_cod", alarme_cod, 0);
        chk("tmo_idle_motor", motor, 0);

        // nivel on the last timeout cycle wins
        tick();
        chk("tmo2_mf", motor, 1);
        garrafa_in = 1'b1; tick(); garrafa_in = 1'b0;
        repeat (49) tick();
        chk("tmo2_valv_last", valvula, 1);
        nivel = 1'b1; tick(); nivel = 1'b0;
        chk("tmo2_ms", motor, 1);
        chk("tmo2_no_alarm", alarme, 0);

        // Seal fault with simultaneous ved_done
        garrafa_ved = 1'b1; tick(); garrafa_ved = 1'b0;
        chk("sf_seal", ved_req, 1);
        ved_alarme = 1'b1; ved_done = 1'b1; tick(); ved_done = 1'b0;
        chk("sf_alarme", alarme, 1);
        chk("sf_cod", alarme_cod, 2);
        chk("sf_stock", rolha_stock, 8);
        chk("sf_unid", unidades, 0);
        ack = 1'b1; tick();
        chk("sf_ack_ignored", alarme, 1);
        chk("sf_cod_held", alarme_cod, 2);
        ved_alarme = 1'b0; tick(); ack = 1'b0;
        chk("sf_ack_ok", alarme, 0);
        chk("sf_cod_clr", alarme_cod, 0);

        // Stop during FILL: bottle finishes, then IDLE
        tick();
        chk("stp_mf", motor, 1);
        garrafa_in = 1'b1; tick(); garrafa_in = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        nivel = 1'b1; tick(); nivel = 1'b0;
        chk("stp_ms_motor", motor, 1);
        garrafa_ved = 1'b1; tick(); garrafa_ved = 1'b0;
        chk("stp_seal", ved_req, 1);
        ved_done = 1'b1; tick(); ved_done = 1'b0;
        chk("stp_idle_motor", motor, 0);
        chk("stp_idle_ved", ved_req, 0);
        chk("stp_stock", rolha_stock, 7);
        chk("stp_unid", unidades, 1);
        tick();
        chk("stp_restart", motor, 1);

        // Run stock down to zero
        repeat (6) garrafa();
        chk("low_stock1", rolha_stock, 1);
        chk("low_baixa", rolha_baixa, 1);
        garrafa();
        chk("low_stock0", rolha_stock, 0);
        chk("low_idle", motor, 0);
        repeat (3) tick();
        chk("low_start_ign", motor, 0);
        recarga = 1'b1; tick(); recarga = 1'b0;
        chk("rec_stock", rolha_stock, 20);
        chk("rec_baixa", rolha_baixa, 0);
        tick();
        chk("rec_resume", motor, 1);
        garrafa();
        chk("rec_stock19", rolha_stock, 19);
        recarga = 1'b1; garrafa(); recarga = 1'b0;
        chk("rec_coinc", rolha_stock, 20);
        chk("rec_coinc_unid", unidades, 10);

        // Async reset between edges while in SEAL
        garrafa_in = 1'b1; tick(); garrafa_in = 1'b0;
        nivel = 1'b1; tick(); nivel = 1'b0;
        garrafa_ved = 1'b1; tick(); garrafa_ved = 1'b0;
        chk("ar_seal", ved_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_ved_req", ved_req, 0);
        chk("ar_motor", motor, 0);
        chk("ar_unid", unidades, 0);
        chk("ar_caixas", caixas, 0);
        chk("ar_stock", rolha_stock, 20);
        #1 reset = 1'b0;

        // Case counter saturation: every input held so a bottle completes every 4 edges
        start = 1'b1; garrafa_in = 1'b1; nivel = 1'b1; garrafa_ved = 1'b1;
        ved_done = 1'b1; recarga = 1'b1;
        repeat (4 * 3059 + 1) tick();
        chk("sat_254", caixas, 254);
        chk("sat_unid11", unidades, 11);
        repeat (4) tick();
        chk("sat_255", caixas, 255);
        chk("sat_pronta", caixa_pronta, 1);
        repeat (48) tick();
        chk("sat_hold", caixas, 255);
        chk("sat_unid0", unidades, 0);
        {start, garrafa_in, nivel, garrafa_ved, ved_done, recarga} = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
